// File: rtl/spi_pixel_packer.sv
// Turns the Rasp-Pi SPI byte stream (sync, image count, RGB triplets) into 24-bit
// pixel words with a one-cycle MMU write strobe, plus progress/done/error status.
module spi_pixel_packer #(
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter logic [31:0] PIX_PER_IMG = 32'd384000,
    parameter logic [7:0]  MAX_IMG     = 8'd31
) (
    input  logic        iCLK_50,
    input  logic        iRST,
    input  logic [7:0]  iByte,
    input  logic        iByte_Valid,
    input  logic        iRestart,
    output logic [23:0] oPix_Data,
    output logic        oTrigger,
    output logic [7:0]  oImg_Tot,
    output logic [4:0]  oImg_Idx,
    output logic [31:0] oPix_Cnt,
    output logic        oDone,
    output logic        oErr
);

    typedef enum logic [2:0] {
        S_SYNC,
        S_HDR,
        S_PIX,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state_reg;
    logic [1:0]  phase_reg;
    logic [7:0]  r_reg;
    logic [7:0]  g_reg;
    logic [31:0] img_pix_reg;
    logic [31:0] total_reg;

    always_ff @(posedge iCLK_50) begin
        if (iRST || iRestart) begin
            state_reg   <= S_SYNC;
            phase_reg   <= 2'd0;
            r_reg       <= 8'd0;
            g_reg       <= 8'd0;
            img_pix_reg <= 32'd0;
            total_reg   <= 32'd0;
            oPix_Data   <= 24'd0;
            oTrigger    <= 1'b0;
            oImg_Tot    <= 8'd0;
            oImg_Idx    <= 5'd0;
            oPix_Cnt    <= 32'd0;
            oDone       <= 1'b0;
            oErr        <= 1'b0;
        end else begin
            oTrigger <= 1'b0;
            if (iByte_Valid) begin
                case (state_reg)
                    S_SYNC: begin
                        if (iByte == SYNC_BYTE)
                            state_reg <= S_HDR;
                    end
                    S_HDR: begin
                        if (iByte != 8'd0 && iByte <= MAX_IMG) begin
                            oImg_Tot  <= iByte;
                            // Product registered once here so the per-byte path has no multiplier
                            total_reg <= 32'(iByte) * PIX_PER_IMG;
                            phase_reg <= 2'd0;
                            state_reg <= S_PIX;
                        end else begin
                            oErr      <= 1'b1;
                            state_reg <= S_ERR;
                        end
                    end
                    S_PIX: begin
                        case (phase_reg)
                            2'd0: begin
                                r_reg     <= iByte;
                                phase_reg <= 2'd1;
                            end
                            2'd1: begin
                                g_reg     <= iByte;
                                phase_reg <= 2'd2;
                            end
                            default: begin
                                oPix_Data <= {r_reg, g_reg, iByte};
                                oTrigger  <= 1'b1;
                                oPix_Cnt  <= oPix_Cnt + 32'd1;
                                phase_reg <= 2'd0;
                                if (oPix_Cnt + 32'd1 == total_reg) begin
                                    // Final pixel: image index stays at oImg_Tot-1
                                    oDone       <= 1'b1;
                                    img_pix_reg <= 32'd0;
                                    state_reg   <= S_DONE;
                                end else if (img_pix_reg == PIX_PER_IMG - 32'd1) begin
                                    img_pix_reg <= 32'd0;
                                    oImg_Idx    <= oImg_Idx + 5'd1;
                                end else begin
                                    img_pix_reg <= img_pix_reg + 32'd1;
                                end
                            end
                        endcase
                    end
                    default: begin
                        // S_DONE and S_ERR ignore bytes until reset or restart
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_pixel_packer.sv
// Scoreboard bench for spi_pixel_packer with a 4-pixel image size.
module tb_spi_pixel_packer;

    logic        iCLK_50 = 1'b0;
    logic        iRST;
    logic [7:0]  iByte;
    logic        iByte_Valid;
    logic        iRestart;
    logic [23:0] oPix_Data;
    logic        oTrigger;
    logic [7:0]  oImg_Tot;
    logic [4:0]  oImg_Idx;
    logic [31:0] oPix_Cnt;
    logic        oDone;
    logic        oErr;

    spi_pixel_packer #(
        .SYNC_BYTE  (8'hA5),
        .PIX_PER_IMG(32'd4),
        .MAX_IMG    (8'd31)
    ) dut (
        .iCLK_50    (iCLK_50),
        .iRST       (iRST),
        .iByte      (iByte),
        .iByte_Valid(iByte_Valid),
        .iRestart   (iRestart),
        .oPix_Data  (oPix_Data),
        .oTrigger   (oTrigger),
        .oImg_Tot   (oImg_Tot),
        .oImg_Idx   (oImg_Idx),
        .oPix_Cnt   (oPix_Cnt),
        .oDone      (oDone),
        .oErr       (oErr)
    );

    always #5 iCLK_50 = ~iCLK_50;

    typedef struct {
        logic [23:0] data;
        logic [31:0] cnt;
        logic [4:0]  idx;
        logic        done;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every trigger must match the next expected pixel
    always @(negedge iCLK_50) begin
        if (oTrigger === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_trigger: got data %06h, expected no trigger", oPix_Data);
            end else begin
                mon_e = exp_q.pop_front();
                check("pix_data", 32'(oPix_Data), 32'(mon_e.data));
                check("pix_cnt", oPix_Cnt, mon_e.cnt);
                check("img_idx", 32'(oImg_Idx), 32'(mon_e.idx));
                check("done_at_trigger", 32'(oDone), 32'(mon_e.done));
                $display("[TB] trigger data=%06h cnt=%0d idx=%0d done=%0b",
                         oPix_Data, oPix_Cnt, oImg_Idx, oDone);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        iByte       = b;
        iByte_Valid = 1'b1;
        @(posedge iCLK_50);
        #1;
        iByte_Valid = 1'b0;
        iByte       = 8'h00;
    endtask

    task automatic send_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                              input logic [31:0] cnt, input logic [4:0] idx, input logic done);
        exp_t e;
        e.data = {r, g, b};
        e.cnt  = cnt;
        e.idx  = idx;
        e.done = done;
        exp_q.push_back(e);
        send_byte(r);
        send_byte(g);
        send_byte(b);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge iCLK_50);
        #1;
    endtask

    task automatic pulse_restart();
        iRestart = 1'b1;
        @(posedge iCLK_50);
        #1;
        iRestart = 1'b0;
        $display("[TB] restart");
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pix_data"}, 32'(oPix_Data), 32'd0);
        check({tag, "_trigger"}, 32'(oTrigger), 32'd0);
        check({tag, "_img_tot"}, 32'(oImg_Tot), 32'd0);
        check({tag, "_img_idx"}, 32'(oImg_Idx), 32'd0);
        check({tag, "_pix_cnt"}, oPix_Cnt, 32'd0);
        check({tag, "_done"}, 32'(oDone), 32'd0);
        check({tag, "_err"}, 32'(oErr), 32'd0);
    endtask

    task automatic check_drained(input string tag);
        idle(3);
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        iRST        = 1'b1;
        iByte       = 8'h00;
        iByte_Valid = 1'b0;
        iRestart    = 1'b0;
        idle(2);
        check_zero("reset");
        iRST = 1'b0;
        idle(1);

        // Two images of four pixels, bytes 01..18
        send_byte(8'hA5);
        send_byte(8'h02);
        check("hdr_img_tot", 32'(oImg_Tot), 32'd2);
        for (int k = 0; k < 8; k++)
            send_pixel(8'(3*k+1), 8'(3*k+2), 8'(3*k+3), 32'(k+1),
                       (k == 7) ? 5'd1 : 5'((k+1)/4), k == 7);
        check_drained("two_img");
        check("two_img_done", 32'(oDone), 32'd1);
        check("two_img_cnt", oPix_Cnt, 32'd8);
        check("two_img_idx", 32'(oImg_Idx), 32'd1);
        check("two_img_last", 32'(oPix_Data), 32'h161718);

        // Bytes after done are ignored
        for (int k = 0; k < 30; k++)
            send_byte(8'(k+8'h40));
        check_drained("post_done");
        check("post_done_cnt", oPix_Cnt, 32'd8);
        check("post_done_data", 32'(oPix_Data), 32'h161718);
        check("post_done_img_tot", 32'(oImg_Tot), 32'd2);

        pulse_restart();
        check_zero("restart_after_done");

        // Garbage ahead of the sync byte
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h3C);
        send_byte(8'hA5);
        send_byte(8'h01);
        check("garbage_img_tot", 32'(oImg_Tot), 32'd1);
        for (int k = 0; k < 4; k++)
            send_pixel(8'(3*k+8'h10), 8'(3*k+8'h11), 8'(3*k+8'h12), 32'(k+1), 5'd0, k == 3);
        check_drained("garbage");
        check("garbage_done", 32'(oDone), 32'd1);
        check("garbage_cnt", oPix_Cnt, 32'd4);

        // Illegal headers
        pulse_restart();
        send_byte(8'hA5);
        send_byte(8'h00);
        check("hdr0_err", 32'(oErr), 32'd1);
        check("hdr0_img_tot", 32'(oImg_Tot), 32'd0);
        for (int k = 0; k < 6; k++)
            send_byte(8'(k+1));
        check_drained("hdr0");
        check("hdr0_err_hold", 32'(oErr), 32'd1);
        pulse_restart();
        send_byte(8'hA5);
        send_byte(8'h20);
        check("hdr32_err", 32'(oErr), 32'd1);
        check("hdr32_img_tot", 32'(oImg_Tot), 32'd0);
        pulse_restart();
        send_byte(8'hA5);
        send_byte(8'h01);
        check("hdr1_err", 32'(oErr), 32'd0);
        check("hdr1_img_tot", 32'(oImg_Tot), 32'd1);

        // Restart coincident with the B byte drops the pixel
        pulse_restart();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        iByte       = 8'h33;
        iByte_Valid = 1'b1;
        iRestart    = 1'b1;
        @(posedge iCLK_50);
        #1;
        iByte_Valid = 1'b0;
        iRestart    = 1'b0;
        check_zero("restart_mid_pix");
        send_byte(8'hA5);
        send_byte(8'h01);
        send_pixel(8'hAA, 8'hBB, 8'hCC, 32'd1, 5'd0, 1'b0);
        check_drained("after_restart");
        check("after_restart_data", 32'(oPix_Data), 32'hAABBCC);
        check("after_restart_done", 32'(oDone), 32'd0);

        // Reset mid-transfer with a partial pixel pending, then full rerun
        pulse_restart();
        send_byte(8'hA5);
        send_byte(8'h03);
        for (int k = 0; k < 5; k++)
            send_pixel(8'(3*k+8'h40), 8'(3*k+8'h41), 8'(3*k+8'h42), 32'(k+1),
                       5'((k+1)/4), 1'b0);
        send_byte(8'h77);
        send_byte(8'h78);
        iRST = 1'b1;
        @(posedge iCLK_50);
        #1;
        iRST = 1'b0;
        check_zero("reset_mid");
        send_byte(8'hA5);
        send_byte(8'h01);
        for (int k = 0; k < 4; k++)
            send_pixel(8'(3*k+8'h60), 8'(3*k+8'h61), 8'(3*k+8'h62), 32'(k+1), 5'd0, k == 3);
        check_drained("rerun");
        check("rerun_done", 32'(oDone), 32'd1);
        check("rerun_cnt", oPix_Cnt, 32'd4);
        check("rerun_data", 32'(oPix_Data), 32'h696A6B);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_pixel_packer.md
Name: spi_pixel_packer

Overview:
- Sits between the SPI slave byte receiver and the memory management unit, in the iCLK_50 domain.
- Parses the Rasp-Pi byte stream: a sync byte, then an image-count byte, then RGB pixels at 3 bytes per pixel.
- Produces the 24-bit pixel word, the single-cycle write trigger and the total image count that the MMU consumes.
- Also tracks progress: pixel count, current image, done and error status.

Parameters:
- SYNC_BYTE, 8'hA5, header marker that opens a transfer.
- PIX_PER_IMG, 32'd384000, pixels per image (800x480).
- MAX_IMG, 8'd31, largest legal image count (current_img is 5-bit downstream).

Ports:
- iCLK_50  in  1  system clock; all logic is on the rising edge.
- iRST  in  1  synchronous reset, active-high.
- iByte  in  8  byte from the SPI slave.
- iByte_Valid  in  1  one-cycle pulse; iByte is valid in that cycle.
- iRestart  in  1  one-cycle pulse; aborts any transfer and returns to S_SYNC.
- oPix_Data  out  24  {R,G,B} of the last completed pixel.
- oTrigger  out  1  one-cycle pulse per completed pixel (MMU write strobe).
- oImg_Tot  out  8  image count latched from the header.
- oImg_Idx  out  5  index of the image currently being received.
- oPix_Cnt  out  32  total pixels emitted since the header.
- oDone  out  1  level; high once all oImg_Tot*PIX_PER_IMG pixels are emitted.
- oErr  out  1  level; high after an illegal header.

Behaviour:
- Reset (iRST=1 at an edge):
  - State goes to S_SYNC.
  - All outputs go to 0: oPix_Data=0, oTrigger=0, oImg_Tot=0, oImg_Idx=0, oPix_Cnt=0, oDone=0, oErr=0.
  - Internal counters are cleared.
  - Reset has priority over everything, including a transfer in progress; a partial pixel is discarded.
- iRestart has the same effect as reset, except that it is only sampled when iRST=0.
  - It beats a coincident iByte_Valid; that byte is dropped.
- Bytes are consumed only in cycles with iByte_Valid=1. All other inputs are ignored outside their own semantics.
- FSM:
  - S_SYNC: byte==SYNC_BYTE -> S_HDR. Any other byte is dropped; state stays S_SYNC.
  - S_HDR: the byte is the image count N.
    - If 1<=N<=MAX_IMG: oImg_Tot<=N at that same edge, then -> S_PIX.
    - Otherwise: oErr<=1, oImg_Tot stays 0, -> S_ERR.
  - S_PIX: a 2-bit byte phase counter runs 0,1,2.
    - Phase 0 stores R, phase 1 stores G.
    - Phase 2: oPix_Data<={R,G,B}, oTrigger<=1 for exactly one cycle (latency: the edge after the B byte is sampled), oPix_Cnt<=oPix_Cnt+1, phase<=0.
    - A per-image counter increments on each pixel. When it reaches PIX_PER_IMG-1 it wraps to 0 and oImg_Idx increments.
    - When the emitted pixel is the last one (oPix_Cnt+1 == oImg_Tot*PIX_PER_IMG, computed in 32 bits), set oDone<=1 in the same edge as the trigger and go to S_DONE.
    - oImg_Idx is not incremented past oImg_Tot-1 on that final pixel.
  - S_DONE: all bytes are ignored. No triggers. Outputs hold. Leave only via iRST or iRestart.
  - S_ERR: all bytes are ignored. oErr holds 1. Leave only via iRST or iRestart.
- oImg_Tot is stable for the entire pixel phase; it changes only at the header, on reset or on restart.
- oPix_Data holds between triggers.
- Back-to-back iByte_Valid on consecutive cycles is legal; the minimum trigger spacing is then 3 cycles.
  - The upstream SPI rate guarantees a trigger spacing of at least WR_LENGTH words. This block does not throttle.
- Arithmetic:
  - oImg_Tot*PIX_PER_IMG is at most 31*384000 = 11,904,000, which fits in 32 bits.
  - The product is registered once at header time. No multiplier sits in the per-byte path.

Test Plan (PIX_PER_IMG=4 for simulation unless noted):
- Sync and header: bytes A5,02, then 24 bytes 01..18 -> oImg_Tot=2 from the header edge.
  - 8 triggers; first oPix_Data=24'h010203, last=24'h161718.
  - oImg_Idx goes 0 then 1 after the 4th pixel.
  - oDone=1 on the 8th trigger edge; oPix_Cnt=8.
- Garbage before sync: bytes 00,FF,3C,A5,01, then 12 pixel bytes -> the first three are ignored; exactly 4 triggers; oDone=1.
- Illegal header: A5,00 -> oErr=1, no triggers. A5,20 (32>MAX_IMG) -> oErr=1. Then iRestart, then A5,01 -> oErr=0, oImg_Tot=1.
- Restart mid-pixel: A5,01,11,22, then iRestart coincident with byte 33 -> no trigger, state S_SYNC, all outputs 0. Next A5,01,AA,BB,CC -> oPix_Data=24'hAABBCC.
- Post-done bytes: after oDone, send 30 further bytes -> no trigger; oPix_Cnt unchanged.
- Reset mid-transfer and full size (PIX_PER_IMG=384000, N=1): assert iRST after 1000 pixels -> all outputs 0 the following cycle. Rerun complete -> exactly 384000 triggers; oDone at trigger 384000.
